// File: rtl/bch_syndrome.sv
// BCH syndrome generator: serial Horner evaluation of S_j = r(alpha^j), j = 1..2t,
// over GF(2^C_M), one received bit per accepted beat, highest-order coefficient first.
`timescale 1ns/1ps
module bch_syndrome #(
  parameter int unsigned C_M         = 5,
  parameter int unsigned C_ERR_NUM   = 4,
  parameter int unsigned C_PRIM_POLY = 37,
  parameter int unsigned C_CNTW      = 8
) (
  input  logic                       I_clk,
  input  logic                       I_rst,
  input  logic                       I_valid,
  input  logic                       I_bit,
  input  logic                       I_sof,
  output logic                       O_ready,
  output logic [2*C_ERR_NUM*C_M-1:0] O_syn,
  output logic                       O_syn_valid,
  output logic                       O_err_det
);

  localparam int unsigned       NSYN = 2 * C_ERR_NUM;
  localparam int unsigned       N    = (1 << C_M) - 1;
  localparam logic [C_M-1:0]    POLY = C_M'(C_PRIM_POLY);
  localparam logic [C_CNTW-1:0] LAST = C_CNTW'(N - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t            state;
  logic [C_CNTW-1:0] cnt;
  logic [C_M-1:0]    syn      [NSYN];
  logic [C_M-1:0]    syn_step [NSYN];
  logic [C_M-1:0]    bit_in;
  logic              step_nz;
  logic              ready;
  logic              syn_valid;
  logic              err_det;
  logic              accept;

  // Constant multiply by alpha^p: p shift-and-reduce steps; p is fixed per syndrome lane.
  function automatic logic [C_M-1:0] mul_alpha_pow(input logic [C_M-1:0] v,
                                                   input int unsigned    p);
    logic [C_M-1:0] r;
    r = v;
    for (int unsigned i = 0; i < p; i++) begin
      if (r[C_M-1]) r = (r << 1) ^ POLY;
      else          r = r << 1;
    end
    return r;
  endfunction

  assign bit_in = {{(C_M-1){1'b0}}, I_bit};
  assign accept = I_valid & ready;

  always_comb begin
    step_nz = 1'b0;
    for (int unsigned j = 0; j < NSYN; j++) begin
      syn_step[j] = mul_alpha_pow(syn[j], j + 1) ^ bit_in;
      step_nz     = step_nz | (|syn_step[j]);
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ready     <= 1'b1;
      syn_valid <= 1'b0;
      err_det   <= 1'b0;
      for (int unsigned j = 0; j < NSYN; j++) syn[j] <= '0;
    end else begin
      syn_valid <= 1'b0;
      err_det   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && I_sof) begin
            for (int unsigned j = 0; j < NSYN; j++) syn[j] <= bit_in;
            cnt   <= C_CNTW'(1);
            state <= ACC;
          end
        end
        ACC: begin
          if (accept) begin
            if (I_sof) begin
              // Restart: the partial frame is discarded without an output pulse.
              for (int unsigned j = 0; j < NSYN; j++) syn[j] <= bit_in;
              cnt <= C_CNTW'(1);
            end else begin
              for (int unsigned j = 0; j < NSYN; j++) syn[j] <= syn_step[j];
              cnt <= cnt + 1'b1;
              if (cnt == LAST) begin
                state     <= DONE;
                ready     <= 1'b0;
                syn_valid <= 1'b1;
                err_det   <= step_nz;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NSYN; g++) begin : g_pack
    assign O_syn[g*C_M +: C_M] = syn[g];
  end

  assign O_ready     = ready;
  assign O_syn_valid = syn_valid;
  assign O_err_det   = err_det;

endmodule

// File: tb/tb_bch_syndrome.sv
// Directed bench for bch_syndrome (m=5, t=4, n=31) with hand-computed syndromes
// and a generator-polynomial codeword built from GF(32) linear factors.
`timescale 1ns/1ps
module tb_bch_syndrome;

  localparam int unsigned W = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic         bitv;
  logic         sof;
  logic         ready;
  logic [W-1:0] syn;
  logic         syn_valid;
  logic         err_det;

  int checks     = 0;
  int errors     = 0;
  int pulses     = 0;
  int ready_bad  = 0;
  int exp_pulses = 0;

  logic [4:0]   apow [31];
  logic [4:0]   g    [21];
  logic [30:0]  gen_cw;
  int           roots [20] = '{1, 2, 4, 8, 16, 3, 6, 12, 24, 17,
                               5, 10, 20, 9, 18, 7, 14, 28, 25, 19};

  logic [W-1:0] s_r0;
  logic [W-1:0] s_r1;

  always #5 clk = ~clk;

  bch_syndrome #(
    .C_M        (5),
    .C_ERR_NUM  (4),
    .C_PRIM_POLY(37),
    .C_CNTW     (8)
  ) dut (
    .I_clk      (clk),
    .I_rst      (rst),
    .I_valid    (valid),
    .I_bit      (bitv),
    .I_sof      (sof),
    .O_ready    (ready),
    .O_syn      (syn),
    .O_syn_valid(syn_valid),
    .O_err_det  (err_det)
  );

  // Pulse counter and ready/pulse exclusivity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (syn_valid === 1'b1) pulses++;
    if (rst === 1'b0 && ready === syn_valid) ready_bad++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] p;
    logic [4:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) p = p ^ x;
      x = x[4] ? ((x << 1) ^ 5'b00101) : (x << 1);
    end
    return p;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    sof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until the DUT accepts it (bounded).
  task automatic beat(input logic b, input logic s);
    int unsigned tries;
    bit          acc;
    tries = 0;
    valid = 1'b1;
    bitv  = b;
    sof   = s;
    do begin
      acc = (ready === 1'b1);
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 4);
    if (!acc) check("beat_accept", {39'b0, acc}, 1);
  endtask

  task automatic send_bits(input logic [30:0] r, input int count, input bit gaps);
    for (int i = 30; i > 30 - count; i--) begin
      if (gaps) begin
        int n;
        n     = $urandom_range(0, 3);
        valid = 1'b0;
        sof   = 1'($urandom);
        bitv  = 1'($urandom);
        repeat (n) begin
          @(posedge clk);
          #1;
        end
      end
      beat(r[i], i == 30);
    end
  endtask

  task automatic send_frame(input string tag, input logic [30:0] r, input bit gaps,
                            input logic [W-1:0] exp_syn, input logic exp_err);
    int p0;
    p0 = pulses + ((syn_valid === 1'b1) ? 1 : 0);
    send_bits(r, 31, gaps);
    check({tag, "_valid"}, {39'b0, syn_valid}, 1);
    check({tag, "_ready"}, {39'b0, ready}, 0);
    check({tag, "_syn"}, syn, exp_syn);
    check({tag, "_err"}, {39'b0, err_det}, {39'b0, exp_err});
    check({tag, "_no_early_pulse"}, W'(pulses - p0), 0);
    exp_pulses++;
  endtask

  initial begin
    s_r0 = {8{5'b00001}};
    s_r1 = {5'b01101, 5'b10100, 5'b01010, 5'b00101,
            5'b10000, 5'b01000, 5'b00100, 5'b00010};

    apow[0] = 5'b00001;
    for (int i = 1; i < 31; i++) apow[i] = gf_mul(apow[i-1], 5'b00010);
    for (int k = 0; k < 21; k++) g[k] = '0;
    g[0] = 5'b00001;
    for (int n = 0; n < 20; n++) begin
      for (int k = n + 1; k >= 1; k--) g[k] = g[k-1] ^ gf_mul(g[k], apow[roots[n]]);
      g[0] = gf_mul(g[0], apow[roots[n]]);
    end
    gen_cw = '0;
    for (int k = 0; k < 21; k++) gen_cw[k] = g[k][0];

    rst   = 1'b1;
    valid = 1'b0;
    bitv  = 1'b0;
    sof   = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("rst_ready", {39'b0, ready}, 1);
    check("rst_valid", {39'b0, syn_valid}, 0);
    check("rst_err", {39'b0, err_det}, 0);
    check("rst_syn", syn, '0);
    rst = 1'b0;
    idle(2);

    send_frame("zero", 31'h0, 1'b0, '0, 1'b0);
    idle(1);
    check("zero_pulse_one_cycle", {39'b0, syn_valid}, 0);
    check("zero_ready_back", {39'b0, ready}, 1);
    idle(2);
    check("zero_pulses", W'(pulses), W'(exp_pulses));

    send_frame("r0", 31'h1, 1'b0, s_r0, 1'b1);
    idle(3);

    send_frame("r1", 31'h2, 1'b0, s_r1, 1'b1);
    idle(3);
    check("r1_hold", syn, s_r1);

    send_frame("gen", gen_cw, 1'b1, '0, 1'b0);
    idle(3);
    check("gen_pulses", W'(pulses), W'(exp_pulses));

    // Eleven garbage bits, then a fresh sof as the 12th bit starts the r_1 frame.
    send_bits(31'h7FFF_FFFF, 11, 1'b0);
    send_frame("restart", 31'h2, 1'b0, s_r1, 1'b1);
    idle(3);
    check("restart_pulses", W'(pulses), W'(exp_pulses));

    send_bits(31'h7FFF_FFFF, 15, 1'b0);
    rst   = 1'b1;
    valid = 1'b1;
    sof   = 1'b1;
    bitv  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_syn", syn, '0);
    check("midrst_valid", {39'b0, syn_valid}, 0);
    check("midrst_err", {39'b0, err_det}, 0);
    check("midrst_ready", {39'b0, ready}, 1);
    idle(40);
    check("midrst_no_pulse", W'(pulses), W'(exp_pulses));

    for (int i = 0; i < 35; i++) beat(1'b1, 1'b0);
    idle(3);
    check("idle_nosof_no_pulse", W'(pulses), W'(exp_pulses));
    check("idle_nosof_syn", syn, '0);

    send_frame("b2b_a", 31'h1, 1'b0, s_r0, 1'b1);
    send_frame("b2b_b", 31'h2, 1'b0, s_r1, 1'b1);
    send_frame("b2b_c", 31'h0, 1'b0, '0, 1'b0);
    idle(3);
    check("b2b_pulses", W'(pulses), W'(exp_pulses));
    check("ready_low_only_in_done", W'(ready_bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
